// File: rtl/rbzero_spi_master_if.sv
// Request/status handshake between a frame producer and rbzero_spi_master.
// The producer side uses modport master; the SPI master core uses modport slave.
interface rbzero_spi_master_if #(
   parameter int MAX_BITS = 32
);
   logic                i_start;
   logic [MAX_BITS-1:0] i_data;
   logic [5:0]          i_len;
   logic                o_ready;
   logic                o_busy;
   logic                o_done;

   modport master (output i_start, i_data, i_len, input o_ready, o_busy, o_done);
   modport slave  (input i_start, i_data, i_len, output o_ready, o_busy, o_done);
endinterface

// File: rtl/rbzero_spi_master.sv
// SPI mode-0 frame transmitter for the rbzero SPI slaves; all SPI lines come from flops.
// Optional one-entry request buffer: define RBZERO_SPI_TX_QUEUE_EN.
module rbzero_spi_master #(
   parameter int CLK_DIV  = 4,
   parameter int MAX_BITS = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   rbzero_spi_master_if.slave bus,
   output logic               o_sclk,
   output logic               o_mosi,
   output logic               o_ss_n
);
   typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, GAP} state_t;

   localparam logic [8:0] PH_LAST  = 9'(CLK_DIV - 1);
   localparam logic [8:0] GAP_DONE = 9'(2*CLK_DIV - 2);
   localparam logic [8:0] GAP_LAST = 9'(2*CLK_DIV - 1);
   localparam logic [6:0] LEN_MAX  = 7'(MAX_BITS);

   state_t              state, state_n;
   logic [8:0]          ph, ph_n;
   logic [6:0]          bits, bits_n;
   logic [MAX_BITS-1:0] sh, sh_n;
   logic                sclk_n, mosi_n, ss_n_n;
   logic                busy, busy_n, done, done_n;
   logic                acc, launch, free;
   logic [MAX_BITS-1:0] ld_data, ld_sh;
   logic [6:0]          ld_len;

   function automatic logic [6:0] clamp_len(input logic [5:0] l);
      return ({1'b0, l} > LEN_MAX) ? LEN_MAX : {1'b0, l};
   endfunction

`ifdef RBZERO_SPI_TX_QUEUE_EN
   logic                q_vld, q_vld_n;
   logic [MAX_BITS-1:0] q_data, q_data_n;
   logic [6:0]          q_len, q_len_n;
   assign bus.o_ready = ~q_vld;
`else
   assign bus.o_ready = (state == IDLE);
`endif

   assign acc        = bus.i_start & bus.o_ready;
   assign bus.o_busy = busy;
   assign bus.o_done = done;

   always_comb begin
      state_n = state;
      ph_n    = ph;
      bits_n  = bits;
      sh_n    = sh;
      sclk_n  = 1'b0;
      mosi_n  = o_mosi;
      ss_n_n  = o_ss_n;
      busy_n  = busy;
      done_n  = 1'b0;
      free    = 1'b0;
      case (state)
         IDLE: free = 1'b1;
         SETUP: begin
            ph_n = ph + 9'd1;
            if (ph == PH_LAST) begin
               state_n = SCK_HI;
               ph_n    = '0;
               sclk_n  = 1'b1;
            end
         end
         SCK_HI: begin
            sclk_n = 1'b1;
            ph_n   = ph + 9'd1;
            if (ph == PH_LAST) begin
               state_n = SCK_LO;
               ph_n    = '0;
               sclk_n  = 1'b0;
               bits_n  = bits - 7'd1;
               // next bit goes out on the falling edge; the last bit just holds
               if (bits != 7'd1) begin
                  sh_n   = sh << 1;
                  mosi_n = sh[MAX_BITS-2];
               end
            end
         end
         SCK_LO: begin
            ph_n = ph + 9'd1;
            if (ph == PH_LAST) begin
               ph_n = '0;
               if (bits == 7'd0) begin
                  state_n = GAP;
                  ss_n_n  = 1'b1;
                  mosi_n  = 1'b0;
               end else begin
                  state_n = SCK_HI;
                  sclk_n  = 1'b1;
               end
            end
         end
         GAP: begin
            ph_n = ph + 9'd1;
            if (ph == GAP_DONE) done_n = 1'b1;
            if (ph == GAP_LAST) begin
               state_n = IDLE;
               ph_n    = '0;
               busy_n  = 1'b0;
               free    = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      launch  = 1'b0;
      ld_data = bus.i_data;
      ld_len  = clamp_len(bus.i_len);
`ifdef RBZERO_SPI_TX_QUEUE_EN
      q_vld_n  = q_vld;
      q_data_n = q_data;
      q_len_n  = q_len;
      // a buffered frame launches straight out of GAP, skipping IDLE
      if (free && q_vld) begin
         launch  = 1'b1;
         ld_data = q_data;
         ld_len  = q_len;
         q_vld_n = 1'b0;
      end else if (free && acc) begin
         launch = 1'b1;
      end else if (acc) begin
         q_vld_n  = 1'b1;
         q_data_n = bus.i_data;
         q_len_n  = clamp_len(bus.i_len);
      end
`else
      launch = free & acc;
`endif

      // right-aligned payload moved so its first bit sits at the MSB
      ld_sh = ld_data << (MAX_BITS - int'(ld_len));
      if (launch) begin
         ph_n = '0;
         if (ld_len == 7'd0) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end else begin
            state_n = SETUP;
            bits_n  = ld_len;
            sh_n    = ld_sh;
            mosi_n  = ld_sh[MAX_BITS-1];
            ss_n_n  = 1'b0;
            busy_n  = 1'b1;
            sclk_n  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ph     <= '0;
         bits   <= '0;
         sh     <= '0;
         o_sclk <= 1'b0;
         o_mosi <= 1'b0;
         o_ss_n <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         ph     <= ph_n;
         bits   <= bits_n;
         sh     <= sh_n;
         o_sclk <= sclk_n;
         o_mosi <= mosi_n;
         o_ss_n <= ss_n_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

`ifdef RBZERO_SPI_TX_QUEUE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_vld  <= 1'b0;
         q_data <= '0;
         q_len  <= '0;
      end else begin
         q_vld  <= q_vld_n;
         q_data <= q_data_n;
         q_len  <= q_len_n;
      end
   end
`endif
endmodule

// File: tb/tb_rbzero_spi_master.sv
// Directed bench for rbzero_spi_master (CLK_DIV=2, MAX_BITS=32) with an SPI capture model as loopback slave.
module tb_rbzero_spi_master;
   logic clk, rst_n;
   logic sclk, mosi, ss_n;
   int   checks = 0;
   int   errors = 0;

   rbzero_spi_master_if #(.MAX_BITS(32)) bus();

   rbzero_spi_master #(.CLK_DIV(2), .MAX_BITS(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .o_sclk (sclk),
      .o_mosi (mosi),
      .o_ss_n (ss_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // slave model: shifts mosi in on every sclk rising edge
   logic [63:0] slave_reg = '0;
   int          edges = 0;
   always @(posedge sclk) begin
      slave_reg <= {slave_reg[62:0], mosi};
      edges     <= edges + 1;
   end

   int cyc = 0, sslow = 0, dones = 0, last_done_cyc = -1000, fall_gap = 0;
   logic prev_ss = 1'b1;
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!ss_n) sslow <= sslow + 1;
      if (bus.o_done) begin
         dones         <= dones + 1;
         last_done_cyc <= cyc;
      end
      if (!ss_n && prev_ss) fall_gap <= cyc - last_done_cyc;
      prev_ss <= ss_n;
   end

   task automatic wait_ready;
      for (int i = 0; i < 1000 && !bus.o_ready; i++) @(negedge clk);
      checks++;
      if (!bus.o_ready) begin
         errors++;
         $display("FAIL ready_timeout: o_ready=%b required 1", bus.o_ready);
      end
   endtask

   task automatic run_frame(input logic [31:0] d, input logic [5:0] l,
                            output int e, output int s, output int dn);
      int e0, s0, d0;
      @(negedge clk);
      wait_ready();
      e0 = edges; s0 = sslow; d0 = dones;
      bus.i_start = 1'b1; bus.i_data = d; bus.i_len = l;
      @(posedge clk); #1 bus.i_start = 1'b0;
      for (int i = 0; i < 2000 && dones == d0; i++) @(negedge clk);
      checks++;
      if (dones == d0) begin
         errors++;
         $display("FAIL done_timeout: dones=%0d required >%0d", dones, d0);
      end
      repeat (2) @(negedge clk);
      e = edges - e0; s = sslow - s0; dn = dones - d0;
   endtask

   task automatic test_reset;
      #12;
      checks += 6;
      if (ss_n !== 1'b1)      begin errors++; $display("FAIL rst_ss_n: got %b want 1", ss_n); end
      if (sclk !== 1'b0)      begin errors++; $display("FAIL rst_sclk: got %b want 0", sclk); end
      if (mosi !== 1'b0)      begin errors++; $display("FAIL rst_mosi: got %b want 0", mosi); end
      if (bus.o_busy !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
      if (bus.o_done !== 1'b0)  begin errors++; $display("FAIL rst_done: got %b want 0", bus.o_done); end
      if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.o_ready); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_basic;
      int e, s, dn;
      run_frame(32'hA5, 6'd8, e, s, dn);
      checks += 4;
      if (e != 8)  begin errors++; $display("FAIL basic_edges: got %0d want 8", e); end
      if (s != 34) begin errors++; $display("FAIL basic_sslow: got %0d want 34", s); end
      if (slave_reg[7:0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", slave_reg[7:0]); end
      if (dn != 1) begin errors++; $display("FAIL basic_done: got %0d want 1", dn); end
   endtask

   task automatic test_full_width;
      int e, s, dn;
      run_frame(32'h8000_0001, 6'd32, e, s, dn);
      checks += 4;
      if (e != 32)  begin errors++; $display("FAIL full_edges: got %0d want 32", e); end
      if (s != 130) begin errors++; $display("FAIL full_sslow: got %0d want 130", s); end
      if (slave_reg[31:0] !== 32'h8000_0001) begin errors++; $display("FAIL full_data: got %h want 80000001", slave_reg[31:0]); end
      if (dn != 1) begin errors++; $display("FAIL full_done: got %0d want 1", dn); end
   endtask

   task automatic test_len_zero;
      int e0, s0;
      @(negedge clk);
      wait_ready();
      e0 = edges; s0 = sslow;
      bus.i_start = 1'b1; bus.i_data = 32'hFFFF_FFFF; bus.i_len = 6'd0;
      @(posedge clk); #1 bus.i_start = 1'b0;
      @(negedge clk);
      checks += 3;
      if (bus.o_done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b want 1", bus.o_done); end
      if (ss_n !== 1'b1)       begin errors++; $display("FAIL len0_ss_n: got %b want 1", ss_n); end
      if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b want 0", bus.o_busy); end
      repeat (3) @(negedge clk);
      checks += 3;
      if (bus.o_done !== 1'b0) begin errors++; $display("FAIL len0_pulse: got %b want 0", bus.o_done); end
      if (edges != e0) begin errors++; $display("FAIL len0_edges: got %0d want %0d", edges, e0); end
      if (sslow != s0) begin errors++; $display("FAIL len0_sslow: got %0d want %0d", sslow, s0); end
   endtask

   task automatic test_len_clamp;
      int e, s, dn;
      run_frame(32'hDEAD_BEEF, 6'd40, e, s, dn);
      checks += 3;
      if (e != 32)  begin errors++; $display("FAIL clamp_edges: got %0d want 32", e); end
      if (s != 130) begin errors++; $display("FAIL clamp_sslow: got %0d want 130", s); end
      if (slave_reg[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL clamp_data: got %h want deadbeef", slave_reg[31:0]); end
   endtask

   task automatic test_reset_mid_frame;
      int e0, d0, e, s, dn;
      @(negedge clk);
      wait_ready();
      e0 = edges; d0 = dones;
      bus.i_start = 1'b1; bus.i_data = 32'hFF; bus.i_len = 6'd8;
      @(posedge clk); #1 bus.i_start = 1'b0;
      for (int i = 0; i < 500 && edges < e0 + 3; i++) @(negedge clk);
      checks++;
      if (edges < e0 + 3) begin errors++; $display("FAIL midrst_wait: edges=%0d want %0d", edges - e0, 3); end
      #2 rst_n = 1'b0;
      #1;
      checks += 4;
      if (ss_n !== 1'b1)       begin errors++; $display("FAIL midrst_ss_n: got %b want 1", ss_n); end
      if (sclk !== 1'b0)       begin errors++; $display("FAIL midrst_sclk: got %b want 0", sclk); end
      if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.o_busy); end
      if (mosi !== 1'b0)       begin errors++; $display("FAIL midrst_mosi: got %b want 0", mosi); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (dones != d0) begin errors++; $display("FAIL midrst_nodone: got %0d want %0d", dones, d0); end
      run_frame(32'h3C, 6'd8, e, s, dn);
      checks += 3;
      if (e != 8)  begin errors++; $display("FAIL postrst_edges: got %0d want 8", e); end
      if (slave_reg[7:0] !== 8'h3C) begin errors++; $display("FAIL postrst_data: got %h want 3c", slave_reg[7:0]); end
      if (dn != 1) begin errors++; $display("FAIL postrst_done: got %0d want 1", dn); end
   endtask

   task automatic test_back_to_back;
      int e0, d0;
      @(negedge clk);
      wait_ready();
      e0 = edges; d0 = dones;
      bus.i_start = 1'b1; bus.i_data = 32'h12; bus.i_len = 6'd8;
      @(posedge clk); #1 bus.i_data = 32'h34;
      @(negedge clk);
      wait_ready();
      @(posedge clk); #1 bus.i_start = 1'b0;
      for (int i = 0; i < 2000 && dones < d0 + 2; i++) @(negedge clk);
      checks++;
      if (dones < d0 + 2) begin errors++; $display("FAIL b2b_timeout: dones=%0d want 2", dones - d0); end
      repeat (2) @(negedge clk);
      checks += 3;
      if (edges - e0 != 16) begin errors++; $display("FAIL b2b_edges: got %0d want 16", edges - e0); end
      if (slave_reg[15:0] !== 16'h1234) begin errors++; $display("FAIL b2b_data: got %h want 1234", slave_reg[15:0]); end
`ifdef RBZERO_SPI_TX_QUEUE_EN
      if (fall_gap != 1) begin errors++; $display("FAIL b2b_gap: got %0d want 1", fall_gap); end
`else
      if (fall_gap < 2) begin errors++; $display("FAIL b2b_gap: got %0d want >=2", fall_gap); end
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      bus.i_start = 1'b0; bus.i_data = '0; bus.i_len = '0;
      test_reset();
      test_basic();
      test_full_width();
      test_len_zero();
      test_len_clamp();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
